// File: rtl/yutorina_if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: IF state encoding and
// active-low enable levels.
package yutorina_if_stage_pkg;
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   typedef enum logic [1:0] {
      IF_STATE_REQ  = 2'd0,
      IF_STATE_HOLD = 2'd1,
      IF_STATE_DROP = 2'd2
   } if_state_e;
endpackage

// File: rtl/yutorina_if_stage_if.sv
// Instruction bus between the fetch stage (master) and the interconnect (slave).
// All control strobes are active-low.
interface yutorina_if_stage_if #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
);
   logic              req_;
   logic [ADDR_W-1:0] addr;
   logic              rdy_;
   logic [DATA_W-1:0] rd_data;

   modport master (output req_, addr, input rdy_, rd_data);
   modport slave  (input req_, addr, output rdy_, rd_data);
endinterface

// File: rtl/yutorina_if_stage.sv
// Instruction-fetch stage: owns the PC, issues word reads, skids one word
// under stall and drains a stale bus transaction after a redirect.
module yutorina_if_stage
   import yutorina_if_stage_pkg::*;
#(
   parameter int                ADDR_W   = 30,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                flush,
   input  logic [ADDR_W-1:0]   new_pc,
   input  logic                br_taken,
   input  logic [ADDR_W-1:0]   br_addr,
   yutorina_if_stage_if.master bus,
   output logic                if_en_,
   output logic [ADDR_W-1:0]   if_pc,
   output logic [DATA_W-1:0]   if_insn
);
   if_state_e         state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] req_addr;
   logic [ADDR_W-1:0] skid_pc;
   logic [DATA_W-1:0] skid_insn;

   logic              rdy;
   logic              redirect;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] next_addr;

   assign rdy       = (bus.rdy_ == ENABLE_);
   // A branch only counts when ID actually holds a valid, unstalled instruction.
   assign redirect  = flush || (br_taken && !stall && (if_en_ == ENABLE_));
   assign target    = flush ? new_pc : br_addr;
   assign next_addr = req_addr + ADDR_W'(1);

   // Released combinationally in reset so a pending transaction is abandoned at once.
   assign bus.req_  = (rst || state == IF_STATE_HOLD) ? DISABLE_ : ENABLE_;
   assign bus.addr  = req_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IF_STATE_REQ;
         pc        <= RESET_PC;
         req_addr  <= RESET_PC;
         skid_pc   <= '0;
         skid_insn <= '0;
         if_en_    <= DISABLE_;
         if_pc     <= '0;
         if_insn   <= '0;
      end else begin
         case (state)
            IF_STATE_REQ: begin
               if (redirect) begin
                  pc     <= target;
                  if_en_ <= DISABLE_;
                  if (rdy) req_addr <= target;
                  else     state    <= IF_STATE_DROP;
               end else if (rdy) begin
                  pc <= next_addr;
                  if (stall) begin
                     skid_pc   <= req_addr;
                     skid_insn <= bus.rd_data;
                     state     <= IF_STATE_HOLD;
                  end else begin
                     if_en_   <= ENABLE_;
                     if_pc    <= req_addr;
                     if_insn  <= bus.rd_data;
                     req_addr <= next_addr;
                  end
               end else if (!stall) begin
                  if_en_ <= DISABLE_;
               end
            end
            IF_STATE_HOLD: begin
               if (redirect) begin
                  pc       <= target;
                  req_addr <= target;
                  if_en_   <= DISABLE_;
                  state    <= IF_STATE_REQ;
               end else if (!stall) begin
                  if_en_   <= ENABLE_;
                  if_pc    <= skid_pc;
                  if_insn  <= skid_insn;
                  req_addr <= pc;
                  state    <= IF_STATE_REQ;
               end
            end
            IF_STATE_DROP: begin
               if (redirect) pc <= target;
               if (redirect || !stall) if_en_ <= DISABLE_;
               // Stale data is discarded; the next request uses the latest target.
               if (rdy) begin
                  req_addr <= redirect ? target : pc;
                  state    <= IF_STATE_REQ;
               end
            end
            default: state <= IF_STATE_REQ;
         endcase
      end
   end
endmodule

// File: tb/tb_yutorina_if_stage.sv
// Bench for yutorina_if_stage: directed scenarios then randomized traffic, all
// compared against a transaction-level fetch model.
module tb_yutorina_if_stage;
   logic        clk;
   logic        rst;
   logic        stall, flush, br_taken;
   logic [29:0] new_pc, br_addr;
   logic        if_en_, if_en2_;
   logic [29:0] if_pc, if_pc2;
   logic [31:0] if_insn, if_insn2;

   int checks = 0;
   int errors = 0;

   yutorina_if_stage_if #(.ADDR_W(30), .DATA_W(32)) bus ();
   yutorina_if_stage_if #(.ADDR_W(30), .DATA_W(32)) bus2 ();

   function automatic logic [31:0] insn_of(input logic [29:0] a);
      return {a, 2'b11} ^ 32'h5A5A_0F0F;
   endfunction

   yutorina_if_stage #(.ADDR_W(30), .DATA_W(32), .RESET_PC(30'h0)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
      .br_taken(br_taken), .br_addr(br_addr), .bus(bus.master),
      .if_en_(if_en_), .if_pc(if_pc), .if_insn(if_insn)
   );

   // Second instance: reset vector at the top of the address space, zero-wait bus.
   assign bus2.rdy_    = 1'b0;
   assign bus2.rd_data = insn_of(bus2.addr);
   yutorina_if_stage #(.ADDR_W(30), .DATA_W(32), .RESET_PC(30'h3FFF_FFFF)) dut2 (
      .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0), .new_pc(30'h0),
      .br_taken(1'b0), .br_addr(30'h0), .bus(bus2.master),
      .if_en_(if_en2_), .if_pc(if_pc2), .if_insn(if_insn2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: next fetch address, one in-flight read (possibly stale), a
   // one-word holding slot, and what ID currently sees.
   logic [29:0] m_pc, m_req, m_hpc, m_opc;
   logic [31:0] m_hinsn, m_oinsn;
   bit          m_held, m_stale, m_valid;

   task automatic model_reset();
      m_pc = 30'h0; m_req = 30'h0; m_hpc = 30'h0; m_opc = 30'h0;
      m_hinsn = 32'h0; m_oinsn = 32'h0;
      m_held = 0; m_stale = 0; m_valid = 0;
   endtask

   task automatic model_step(input bit st, input bit fl, input logic [29:0] np,
                             input bit bt, input logic [29:0] ba, input bit rdy,
                             input logic [31:0] d);
      bit          redirect, was_held, accept, dlv;
      logic [29:0] tgt, dpc;
      logic [31:0] dins;
      redirect = fl || (bt && !st && m_valid);
      tgt      = fl ? np : ba;
      was_held = m_held;
      accept   = !was_held && rdy;
      dlv = 0; dpc = 30'h0; dins = 32'h0;
      if (was_held) begin
         if (redirect) m_held = 0;
         else if (!st) begin dlv = 1; dpc = m_hpc; dins = m_hinsn; m_held = 0; end
      end else if (accept && !m_stale && !redirect) begin
         m_pc = m_req + 30'd1;
         if (st) begin m_held = 1; m_hpc = m_req; m_hinsn = d; end
         else begin dlv = 1; dpc = m_req; dins = d; end
      end
      if (redirect) m_pc = tgt;
      if (!was_held) begin
         if (accept) m_stale = 0;
         else if (redirect) m_stale = 1;
      end
      // A read still on the bus keeps its address; otherwise fetch from the PC.
      if (!m_held && !(!was_held && !accept)) m_req = m_pc;
      if (redirect) m_valid = 0;
      else if (dlv) begin m_valid = 1; m_opc = dpc; m_oinsn = dins; end
      else if (!st) m_valid = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Entered just after a rising edge; drives one cycle and checks both sides of the edge.
   task automatic step(input bit st, input bit fl, input logic [29:0] np,
                       input bit bt, input logic [29:0] ba, input bit rdy);
      logic [31:0] d;
      stall = st; flush = fl; new_pc = np; br_taken = bt; br_addr = ba;
      d = rdy ? insn_of(bus.addr) : $urandom;
      bus.rdy_ = !rdy;
      bus.rd_data = d;
      chk("bus_req_", 32'(bus.req_), 32'(m_held));
      if (!m_held) chk("bus_addr", 32'(bus.addr), 32'(m_req));
      @(posedge clk);
      model_step(st, fl, np, bt, ba, rdy, d);
      #1;
      chk("if_en_", 32'(if_en_), 32'(!m_valid));
      chk("if_pc", 32'(if_pc), 32'(m_opc));
      chk("if_insn", if_insn, m_oinsn);
   endtask

   task automatic idle(input bit rdy);
      step(0, 0, 30'h0, 0, 30'h0, rdy);
   endtask

   initial begin
      rst = 1'b1; stall = 0; flush = 0; br_taken = 0; new_pc = 30'h0; br_addr = 30'h0;
      bus.rdy_ = 1'b1; bus.rd_data = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      // reset state
      chk("rst_bus_req_", 32'(bus.req_), 32'd1);
      chk("rst_bus2_req_", 32'(bus2.req_), 32'd1);
      chk("rst_if_en_", 32'(if_en_), 32'd1);
      chk("rst_if_pc", 32'(if_pc), 32'd0);
      chk("rst_if_insn", if_insn, 32'd0);
      chk("rst_bus_addr", 32'(bus.addr), 32'd0);
      chk("rst_bus2_addr", 32'(bus2.addr), 32'h3FFF_FFFF);
      rst = 1'b0;
      model_reset();
      #1;

      // zero-wait streaming, plus the wrapping instance
      idle(1);
      chk("t1_if_pc0", 32'(if_pc), 32'd0);
      chk("t6_if_pc_top", 32'(if_pc2), 32'h3FFF_FFFF);
      chk("t6_if_en_top", 32'(if_en2_), 32'd0);
      chk("t6_bus2_wrap", 32'(bus2.addr), 32'd0);
      idle(1);
      chk("t6_if_pc_wrap", 32'(if_pc2), 32'd0);
      chk("t6_if_insn_wrap", if_insn2, insn_of(30'h0));
      idle(1);
      chk("t1_if_pc2", 32'(if_pc), 32'd2);
      idle(1);

      // 3-cycle bus latency
      for (int i = 0; i < 2; i++) begin
         idle(0);
         idle(0);
         chk("t2_bubble", 32'(if_en_), 32'd1);
         idle(1);
      end
      chk("t2_if_pc5", 32'(if_pc), 32'd5);

      // stall on the returning read -> skid
      idle(1);
      step(1, 0, 30'h0, 0, 30'h0, 1);
      chk("t3_hold_pc", 32'(if_pc), 32'd6);
      chk("t3_req_released", 32'(bus.req_), 32'd1);
      step(1, 0, 30'h0, 0, 30'h0, 1);
      idle(0);
      chk("t3_skid_out", 32'(if_pc), 32'd7);
      chk("t3_next_addr", 32'(bus.addr), 32'd8);

      // branch while read outstanding -> stale read drained
      step(0, 1, 30'd10, 0, 30'h0, 0);
      idle(1);
      idle(1);
      chk("t4_if_pc10", 32'(if_pc), 32'd10);
      step(0, 0, 30'h0, 1, 30'h40, 0);
      idle(0);
      chk("t4_drop_addr", 32'(bus.addr), 32'd11);
      idle(0);
      idle(1);
      chk("t4_no_stale", 32'(if_en_), 32'd1);
      chk("t4_target_addr", 32'(bus.addr), 32'h40);
      idle(1);
      chk("t4_if_pc_tgt", 32'(if_pc), 32'h40);

      // flush while holding under stall
      step(1, 0, 30'h0, 0, 30'h0, 1);
      step(1, 1, 30'h100, 0, 30'h0, 0);
      chk("t5_flush_en_", 32'(if_en_), 32'd1);
      chk("t5_flush_addr", 32'(bus.addr), 32'h100);
      idle(1);
      chk("t5_if_pc", 32'(if_pc), 32'h100);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [29:0] t1, t2;
         t1 = ($urandom_range(0, 3) == 0) ? (30'h3FFF_FFFE + 30'($urandom_range(0, 1))) : 30'($urandom);
         t2 = 30'($urandom);
         step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, t1,
              $urandom_range(0, 9) == 0, t2, $urandom_range(0, 1) == 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
